// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings for the slave memory and its bench.
package ahb_pkg;

  // Transfer type carried on htrans.
  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  // Transfer size carried on hsize (only the sizes a 64-bit bus can carry are named).
  typedef enum logic [2:0] {
    HsizeByte  = 3'd0,
    HsizeHalf  = 3'd1,
    HsizeWord  = 3'd2,
    HsizeDword = 3'd3
  } hsize_e;

  // Slave response carried on hresp.
  typedef enum logic {
    HrespOkay  = 1'b0,
    HrespError = 1'b1
  } hresp_e;

  // Slave data-phase controller states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr1 = 2'd2,
    StErr2 = 2'd3
  } slv_state_e;

  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module ahb_mem_array
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                     clk_i,
  input  logic [DATA_WIDTH/8-1:0]  be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(NumBytes); b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-lite slave memory: address-phase decode and checking, wait-state / two-cycle
// ERROR controller, and byte-lane access to the backing array in the completing cycle.
module ahb_lite_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned LaneW    = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(DEPTH);
  // One extra bit so the size compare cannot wrap when the memory fills the address space.
  localparam logic [ADDR_WIDTH:0] MemBytes = (ADDR_WIDTH+1)'(DEPTH * NumBytes);

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------
  htrans_e               trans;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] offset;
  logic [LaneW-1:0]      lane;
  logic                  out_of_range;
  logic                  oversize;
  logic                  misaligned;
  logic                  addr_err;
  logic [NumBytes-1:0]   be;

  assign trans  = htrans_e'(htrans);
  assign accept = hsel && hready && (trans == HtransNonseq || trans == HtransSeq);
  assign offset = haddr - BASE_ADDR;
  assign lane   = offset[LaneW-1:0];

  assign out_of_range = (haddr < BASE_ADDR) || ({1'b0, offset} >= MemBytes);
  assign oversize     = 32'(hsize) > LaneW;
  assign addr_err     = out_of_range || oversize || misaligned;

  // Alignment check against the transfer size; sizes beyond a dword are flagged anyway.
  always_comb begin
    misaligned = 1'b1;
    case (hsize_e'(hsize))
      HsizeByte:  misaligned = 1'b0;
      HsizeHalf:  misaligned = haddr[0];
      HsizeWord:  misaligned = |haddr[1:0];
      HsizeDword: misaligned = |haddr[2:0];
      default:    misaligned = 1'b1;
    endcase
  end

  // Byte lanes covered by the transfer, starting at the addressed lane.
  always_comb begin
    be = '0;
    for (int i = 0; i < int'(NumBytes); i++) begin
      if (i >= int'(lane) && i < int'(lane) + (1 << hsize)) begin
        be[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data-phase registers
  // ---------------------------------------------------------------------------
  slv_state_e          state_q;
  logic [3:0]          cnt_q;
  logic                hreadyout_q;
  logic                hresp_q;
  logic                dp_valid_q;
  logic                dp_write_q;
  logic                dp_err_q;
  logic [2:0]          dp_size_q;
  logic [IdxW-1:0]     dp_idx_q;
  logic [NumBytes-1:0] dp_be_q;
  logic                dp_advance;

  // The pipeline only moves on when the bus is ready and we are not stalling it ourselves.
  assign dp_advance = hready && (state_q == StIdle || state_q == StErr2);

  // Capture the accepted address phase for use in the following data phase.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_err_q   <= 1'b0;
      dp_size_q  <= '0;
      dp_idx_q   <= '0;
      dp_be_q    <= '0;
    end else if (dp_advance) begin
      dp_valid_q <= accept;
      if (accept) begin
        dp_write_q <= hwrite;
        dp_err_q   <= addr_err;
        dp_size_q  <= hsize;
        dp_idx_q   <= offset[LaneW +: IdxW];
        dp_be_q    <= be;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response controller
  // ---------------------------------------------------------------------------
  // Single-process FSM; hreadyout/hresp are registered alongside the state.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RespOkay;
    end else begin
      unique case (state_q)
        StIdle, StErr2: begin
          state_q     <= StIdle;
          hreadyout_q <= 1'b1;
          hresp_q     <= RespOkay;
          if (accept) begin
            if (addr_err) begin
              state_q     <= StErr1;
              hreadyout_q <= 1'b0;
              hresp_q     <= RespError;
            end else if (WAIT_STATES != 0) begin
              state_q     <= StWait;
              cnt_q       <= 4'(WAIT_STATES);
              hreadyout_q <= 1'b0;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // ERR2 always follows, whatever the master does meanwhile.
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= RespError;
        end
        default: begin
          state_q     <= StIdle;
          cnt_q       <= '0;
          hreadyout_q <= 1'b1;
          hresp_q     <= RespOkay;
        end
      endcase
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

  // ---------------------------------------------------------------------------
  // Memory access in the completing data-phase cycle
  // ---------------------------------------------------------------------------
  logic                  complete;
  logic                  rd_complete;
  logic [NumBytes-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] hrdata_q;

  assign complete    = dp_valid_q && !dp_err_q && (state_q == StIdle);
  assign rd_complete = complete && !dp_write_q;
  // A reset landing on the completing edge still drops the write.
  assign mem_be      = (complete && dp_write_q && !hreset) ? dp_be_q : '0;

  ahb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (hclk),
    .be_i    (mem_be),
    .addr_i  (dp_idx_q),
    .wdata_i (hwdata),
    .rdata_o (mem_rdata)
  );

  // Remember the last read word so hrdata holds steady between read completions.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hrdata_q <= '0;
    end else if (rd_complete) begin
      hrdata_q <= mem_rdata;
    end
  end

  assign hrdata = rd_complete ? mem_rdata : hrdata_q;

  // hburst/hprot carry no meaning for a flat memory; dp_size_q is kept for debug visibility.
  logic unused_sigs;
  assign unused_sigs = ^{hburst, hprot, dp_size_q};

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: two instances (zero and three wait states, different bases)
// driven by a pipelined master and checked against a byte-level memory model.
module tb_ahb_lite_slave_mem;
  import ahb_pkg::*;

  logic        clk;
  logic        hreset_a    [2];
  logic        hsel_a      [2];
  logic [31:0] haddr_a     [2];
  logic [1:0]  htrans_a    [2];
  logic        hwrite_a    [2];
  logic [2:0]  hsize_a     [2];
  logic [2:0]  hburst_a    [2];
  logic [3:0]  hprot_a     [2];
  logic        hready_a    [2];
  logic [31:0] hwdata_a    [2];
  logic [31:0] hrdata_a    [2];
  logic        hreadyout_a [2];
  logic        hresp_a     [2];

  int unsigned ws_m   [2] = '{0, 3};
  logic [31:0] base_m [2] = '{32'h0000_0000, 32'h0000_2000};

  int checks = 0;
  int errors = 0;

  // Byte-level reference memory and the last word each slave returned on a read.
  logic [7:0]  mem_m   [2][1024];
  logic [31:0] last_rd [2];
  logic [31:0] last_dut[2];

  typedef struct {
    bit          gap;
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t q[$];

  ahb_lite_slave_mem #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (256), .WAIT_STATES (0), .BASE_ADDR (32'h0000_0000)
  ) u_dut0 (
    .hclk (clk), .hreset (hreset_a[0]), .hsel (hsel_a[0]), .haddr (haddr_a[0]),
    .htrans (htrans_a[0]), .hwrite (hwrite_a[0]), .hsize (hsize_a[0]), .hburst (hburst_a[0]),
    .hprot (hprot_a[0]), .hready (hready_a[0]), .hwdata (hwdata_a[0]), .hrdata (hrdata_a[0]),
    .hreadyout (hreadyout_a[0]), .hresp (hresp_a[0])
  );

  ahb_lite_slave_mem #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (256), .WAIT_STATES (3), .BASE_ADDR (32'h0000_2000)
  ) u_dut1 (
    .hclk (clk), .hreset (hreset_a[1]), .hsel (hsel_a[1]), .haddr (haddr_a[1]),
    .htrans (htrans_a[1]), .hwrite (hwrite_a[1]), .hsize (hsize_a[1]), .hburst (hburst_a[1]),
    .hprot (hprot_a[1]), .hready (hready_a[1]), .hwdata (hwdata_a[1]), .hrdata (hrdata_a[1]),
    .hreadyout (hreadyout_a[1]), .hresp (hresp_a[1])
  );

  // Each slave is alone on its bus, so the mux simply returns its own ready.
  assign hready_a[0] = hreadyout_a[0];
  assign hready_a[1] = hreadyout_a[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int d, input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    off = addr - base_m[d];
    return (addr >= base_m[d]) && (off < 32'd1024) && (size <= 3'd2) &&
           ((addr % (32'd1 << size)) == 32'd0);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] addr);
    int o;
    o = int'((addr - base_m[d]) & ~32'd3);
    return {mem_m[d][o+3], mem_m[d][o+2], mem_m[d][o+1], mem_m[d][o]};
  endfunction

  task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
    int o;
    o = int'(addr - base_m[d]);
    for (int b = 0; b < (1 << size); b++) begin
      mem_m[d][o+b] = wdata[8*((o+b)%4) +: 8];
    end
  endtask

  task automatic push(input bit write, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    xfer_t x;
    x.gap = 1'b0; x.sel = 1'b1; x.trans = HtransNonseq; x.write = write;
    x.addr = addr; x.size = size; x.wdata = wdata;
    q.push_back(x);
  endtask

  task automatic push_gap(input bit sel, input logic [1:0] trans);
    xfer_t x;
    x.gap = 1'b1; x.sel = sel; x.trans = trans; x.write = 1'b0;
    x.addr = '0; x.size = '0; x.wdata = '0;
    q.push_back(x);
  endtask

  // Pipelined master: drains q on slave d, checking every data-phase cycle against the model.
  task automatic run(input int d);
    xfer_t ap, dp;
    bit    ap_v, dp_v, rdy, err;
    int    waits, cyc;
    logic [31:0] exp;
    ap_v = 1'b0; dp_v = 1'b0; waits = 0; cyc = 0;
    if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
    while (ap_v || dp_v) begin
      if (ap_v && !ap.gap) begin
        hsel_a[d] = 1'b1; htrans_a[d] = HtransNonseq; haddr_a[d] = ap.addr;
        hwrite_a[d] = ap.write; hsize_a[d] = ap.size;
      end else if (ap_v) begin
        hsel_a[d] = ap.sel; htrans_a[d] = ap.trans; haddr_a[d] = $urandom;
        hwrite_a[d] = 1'($urandom); hsize_a[d] = 3'($urandom);
      end else begin
        hsel_a[d] = 1'b0; htrans_a[d] = HtransIdle;
      end
      hburst_a[d] = 3'($urandom);
      hprot_a[d]  = 4'($urandom);
      hwdata_a[d] = (dp_v && dp.write) ? dp.wdata : $urandom;
      @(negedge clk);
      rdy = hreadyout_a[d];
      if (!dp_v || dp.gap) begin
        chk("idle_ready", rdy, 1);
        chk("idle_resp", hresp_a[d], 0);
        chk("idle_rdata_hold", hrdata_a[d], last_rd[d]);
      end else begin
        err = !legal(d, dp.addr, dp.size);
        chk("resp", hresp_a[d], err);
        if (!rdy) begin
          waits++;
          chk("wait_rdata_hold", hrdata_a[d], last_rd[d]);
        end else begin
          chk("wait_states", waits, err ? 1 : ws_m[d]);
          if (!err && !dp.write) begin
            exp = model_word(d, dp.addr);
            chk("rdata", hrdata_a[d], exp);
            last_rd[d]  = exp;
            last_dut[d] = hrdata_a[d];
          end else begin
            chk("rdata_hold", hrdata_a[d], last_rd[d]);
            if (!err) model_write(d, dp.addr, dp.size, dp.wdata);
          end
          waits = 0;
        end
      end
      cyc++;
      if (waits > 40 || cyc > 20000) begin
        errors++;
        $display("FAIL cycle_budget: slave %0d stalled (waits %0d cycles %0d)", d, waits, cyc);
        $fatal(1, "cycle budget exceeded");
      end
      @(posedge clk); #1;
      if (rdy) begin
        dp = ap; dp_v = ap_v; ap_v = 1'b0;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
      end
    end
    hsel_a[d] = 1'b0;
    htrans_a[d] = HtransIdle;
  endtask

  initial begin
    logic [31:0] v, old, addr;
    logic [2:0]  sz;
    int          r;

    for (int d = 0; d < 2; d++) begin
      hreset_a[d] = 1'b1; hsel_a[d] = 1'b0; haddr_a[d] = '0; htrans_a[d] = HtransIdle;
      hwrite_a[d] = 1'b0; hsize_a[d] = '0; hburst_a[d] = '0; hprot_a[d] = '0; hwdata_a[d] = '0;
      last_rd[d] = '0; last_dut[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_hreadyout", hreadyout_a[d], 1);
      chk("reset_hresp", hresp_a[d], 0);
      chk("reset_hrdata", hrdata_a[d], 0);
    end
    @(posedge clk); #1;
    hreset_a[0] = 1'b0; hreset_a[1] = 1'b0;

    // Give every word a known value so later reads never see uninitialised storage.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) push(1'b1, base_m[d] + 32'(4 * i), 3'd2, $urandom);
      run(d);
    end

    // Word write/read with no wait states.
    push(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF); push(1'b0, 32'h10, 3'd2, '0); run(0);
    chk("deadbeef", last_dut[0], 32'hDEAD_BEEF);

    // Byte write into lane 1; other lanes of hwdata carry junk that must be ignored.
    push(1'b1, 32'h10, 3'd2, 32'h1122_3344); push(1'b1, 32'h11, 3'd0, 32'h5A5A_AA5A);
    push(1'b0, 32'h10, 3'd2, '0); run(0);
    chk("byte_lane", last_dut[0], 32'h1122_AA44);

    // Out-of-range and misaligned transfers, each followed straight away by a legal one.
    push(1'b1, 32'h400, 3'd2, $urandom); push(1'b0, 32'h400, 3'd2, '0);
    push(1'b1, 32'h03, 3'd1, 32'hFFFF_FFFF); push(1'b0, 32'h04, 3'd2, '0);
    push(1'b0, 32'h00, 3'd2, '0); push(1'b0, 32'h10, 3'd2, '0); run(0);

    // Master drops to IDLE while ERR1 is showing; ERR2 must still be presented.
    hsel_a[0] = 1'b1; htrans_a[0] = HtransNonseq; haddr_a[0] = 32'h400;
    hwrite_a[0] = 1'b0; hsize_a[0] = 3'd2;
    @(posedge clk); #1;
    htrans_a[0] = HtransIdle;
    @(negedge clk);
    chk("err1_hreadyout", hreadyout_a[0], 0);
    chk("err1_hresp", hresp_a[0], 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err2_hreadyout", hreadyout_a[0], 1);
    chk("err2_hresp", hresp_a[0], 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_err_hreadyout", hreadyout_a[0], 1);
    chk("post_err_hresp", hresp_a[0], 0);
    @(posedge clk); #1;
    hsel_a[0] = 1'b0;

    // Back-to-back write then read of the same word.
    v = $urandom;
    push(1'b1, 32'h20, 3'd2, v); push(1'b0, 32'h20, 3'd2, '0); run(0);
    chk("raw_pipelined", last_dut[0], v);

    // Three-wait-state slave: plain access plus the error classes, including below-base.
    v = $urandom;
    push(1'b1, 32'h2010, 3'd2, v); push(1'b0, 32'h2010, 3'd2, '0); run(1);
    chk("ws3_read", last_dut[1], v);
    push(1'b0, 32'h1FFC, 3'd2, '0); push(1'b0, 32'h2400, 3'd2, '0);
    push(1'b0, 32'h2000, 3'd3, '0); push(1'b1, 32'h2002, 3'd2, $urandom);
    push(1'b0, 32'h2000, 3'd2, '0); push(1'b1, 32'h2006, 3'd1, $urandom);
    push(1'b0, 32'h2004, 3'd2, '0); run(1);

    // Randomised mix on both slaves, including idle/busy/unselected gaps.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
          if ($urandom_range(0, 1) == 1) push_gap(1'b1, ($urandom_range(0, 1) == 1) ? HtransBusy : HtransIdle);
          else push_gap(1'b0, HtransNonseq);
        end else begin
          sz = 3'($urandom_range(0, (r == 1) ? 3 : 2));
          if (r == 2) addr = base_m[d] + 32'd1024 + 32'($urandom_range(0, 4095));
          else addr = base_m[d] + 32'($urandom_range(0, 1023));
          if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << sz) - 32'd1);
          push(1'($urandom), addr, sz, $urandom);
        end
      end
      run(d);
    end

    // Reset during the wait states of a write: write is lost, outputs return to reset values.
    addr = 32'h2040;
    old  = model_word(1, addr);
    hsel_a[1] = 1'b1; htrans_a[1] = HtransNonseq; haddr_a[1] = addr;
    hwrite_a[1] = 1'b1; hsize_a[1] = 3'd2;
    @(posedge clk); #1;
    hsel_a[1] = 1'b0; htrans_a[1] = HtransIdle; hwdata_a[1] = ~old;
    @(negedge clk);
    chk("wait_before_reset", hreadyout_a[1], 0);
    @(posedge clk); #1;
    hreset_a[1] = 1'b1;
    @(posedge clk); #1;
    hreset_a[1] = 1'b0;
    @(negedge clk);
    chk("midreset_hreadyout", hreadyout_a[1], 1);
    chk("midreset_hresp", hresp_a[1], 0);
    chk("midreset_hrdata", hrdata_a[1], 0);
    last_rd[1] = '0;
    @(posedge clk); #1;
    push(1'b0, addr, 3'd2, '0); run(1);
    chk("write_discarded", last_dut[1], old);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
